sin_meas: RTL
=============

// Module: sin_meas
// PURPOSE
// - Receive-side counterpart of the DDS sine path: samples the looped-back analog output via ADC.
// - Measures the period (sum over NCYC full cycles) and the min/max/peak-to-peak amplitude.
// - Sits between the ADC capture register and the control/display logic for closed-loop checks of freq/amp settings.
// - ADC codes are offset binary, midscale 8192 (same coding as DAC_in).
// PARAMETERS
// - DATA_W   14        ADC sample width
// - MID      8192      midscale code, the zero-crossing reference
// - HYST     64        crossing hysteresis; thresholds are MID+HYST and MID-HYST
// - NCYC     4         rising crossings counted per measurement, range 1..15
// - CNT_W    24        period counter width
// - TIMEOUT  16777215  clocks allowed per measurement before err
// PORTS
// - clk         in   1       system clock, rising edge
// - rst_n       in   1       synchronous reset, active low
// - en          in   1       block enable; 0 forces IDLE on the next clock
// - adc_in      in   DATA_W  ADC sample, one valid sample per clk
// - meas_start  in   1       1-clk pulse; starts a measurement from IDLE
// - busy        out  1       high from the accepted start until done/err
// - done        out  1       1-clk pulse; results valid
// - err         out  1       1-clk pulse; timeout, results not updated
// - period      out  CNT_W   clocks spanning NCYC full cycles
// - vmax        out  DATA_W  maximum sample seen during MEASURE
// - vmin        out  DATA_W  minimum sample seen during MEASURE
// - vpp         out  DATA_W  vmax - vmin, unsigned
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE; busy=done=err=0; period=vmax=vmin=vpp=0; comparator level=low.
// - Comparator: registered level with hysteresis.
//   - Goes high when sample >= MID+HYST; goes low when sample <= MID-HYST; otherwise holds.
//   - rise = level goes 0->1, registered, so 1 clk after the qualifying sample.
// - FSM:
//   - IDLE: meas_start & en -> ARM; busy=1 from the next clock. meas_start outside IDLE is ignored.
//   - ARM: wait for level=low (so a partial cycle is never timed) -> WAIT_RISE.
//   - WAIT_RISE: on rise: cnt=0, ncnt=0, run_max=run_min=current sample -> MEASURE.
//   - MEASURE: cnt+1 each clk; run_max/run_min updated each clk; ncnt+1 on each rise.
//     When ncnt reaches NCYC: latch period=cnt+1, vmax, vmin, vpp -> DONE.
//   - DONE: done=1 for exactly one clk, busy=0 in the same clk -> IDLE.
//   - ERR: err=1 for one clk, busy=0, outputs keep previous results -> IDLE.
// - Timeout:
//   - Separate counter, cleared on the accepted start and incremented in ARM/WAIT_RISE/MEASURE.
//   - Reaching TIMEOUT -> ERR. Timeout takes priority over a crossing in the same clk.
// - Counter saturation: cnt saturates at 2^CNT_W-1 and does not wrap.
// - en=0 in any state: next state is IDLE, busy=0, no done/err, result registers keep their values.
// - Reset mid-measurement: immediate return to the full reset values; no done/err pulse.
// - Output timing: all outputs registered; results change only in the DONE clk.
// - Latency: done asserts 1 clk after the NCYC-th rise is registered.
// - vpp is computed from the final run_max/run_min and never goes negative (vmax >= vmin by construction).
// CONFIGURATION
// - SIN_MEAS_FILTER_EN defined:
//   - A 2-tap average (s[n]+s[n-1])>>1 is inserted ahead of the comparator and min/max.
//   - All detection moves 1 clk later; the filter register resets to MID.
// - SIN_MEAS_FILTER_EN undefined: raw adc_in feeds the comparator and min/max directly.
// TESTING
// 1. Sine, period 1000 clk, amplitude +/-4000 around 8192, NCYC=4, start pulse
//    -> done once; period=4000; vmax=12192; vmin=4192; vpp=8000; busy high until done.
// 2. Constant adc_in=8192, start, TIMEOUT overridden to 5000
//    -> err pulse at 5000 clk after start; busy drops; period/vmax/vmin/vpp unchanged.
// 3. Square 8150/8234 (inside +/-HYST=64), start
//    -> no rise detected; err on timeout; comparator level stays low.
// 4. Start pulse during MEASURE of scenario 1
//    -> ignored; a single done with period=4000.
// 5. rst_n=0 for 1 clk mid-MEASURE
//    -> next clk all outputs 0, state IDLE, no done/err; a new start completes normally.
// 6. en dropped to 0 during WAIT_RISE, then raised again with a new start
//    -> busy=0 next clk; new measurement yields period=4000 (scenario 1 stimulus).

Source files
------------

// File: rtl/sin_meas_if.sv
// Handshake/bus bundle for sin_meas: control inputs, ADC sample stream and measurement results.
// master drives en/adc_in/meas_start; slave (the measurement block) drives status and results.
interface sin_meas_if #(
  parameter int DATA_W = 14,
  parameter int CNT_W  = 24
);
  logic              en;
  logic [DATA_W-1:0] adc_in;
  logic              meas_start;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  period;
  logic [DATA_W-1:0] vmax;
  logic [DATA_W-1:0] vmin;
  logic [DATA_W-1:0] vpp;

  modport master (
    output en, adc_in, meas_start,
    input  busy, done, err, period, vmax, vmin, vpp
  );

  modport slave (
    input  en, adc_in, meas_start,
    output busy, done, err, period, vmax, vmin, vpp
  );
endinterface

// File: rtl/sin_meas.sv
// Sine receive check: hysteresis crossing detector, period over NCYC cycles, min/max/p-p amplitude.
// Optional 2-tap input average ahead of detection when SIN_MEAS_FILTER_EN is defined.
module sin_meas #(
  parameter int DATA_W  = 14,
  parameter int MID     = 8192,
  parameter int HYST    = 64,
  parameter int NCYC    = 4,
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 16777215
) (
  input logic       clk,
  input logic       rst_n,
  sin_meas_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W:0] TH_HI = (DATA_W+1)'(MID + HYST);
  localparam logic [DATA_W:0] TH_LO = (DATA_W+1)'(MID - HYST);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  logic [DATA_W-1:0] smp;

`ifdef SIN_MEAS_FILTER_EN
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] filt_q;
  logic [DATA_W:0]   fsum;

  assign fsum = {1'b0, bus.adc_in} + {1'b0, prev_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= DATA_W'(MID);
      filt_q <= DATA_W'(MID);
    end else begin
      prev_q <= bus.adc_in;
      filt_q <= fsum[DATA_W:1];
    end
  end

  assign smp = filt_q;
`else
  assign smp = bus.adc_in;
`endif

  // Comparator level holds inside the hysteresis band; rise is registered with the level.
  logic level_q, level_d, rise_q;

  always_comb begin
    level_d = level_q;
    if ({1'b0, smp} >= TH_HI)      level_d = 1'b1;
    else if ({1'b0, smp} <= TH_LO) level_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
    end
  end

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]        ncnt_q, ncnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
  logic              tmo_hit;
  logic [DATA_W-1:0] rmax_q, rmax_d, rmin_q, rmin_d, cur_max, cur_min;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [DATA_W-1:0] vmax_q, vmax_d, vmin_q, vmin_d, vpp_q, vpp_d;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign tmo_inc = tmo_q + TMO_W'(1);
  assign tmo_hit = (tmo_inc == TMO_W'(TIMEOUT));
  assign cur_max = (smp > rmax_q) ? smp : rmax_q;
  assign cur_min = (smp < rmin_q) ? smp : rmin_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ncnt_d   = ncnt_q;
    tmo_d    = tmo_q;
    rmax_d   = rmax_q;
    rmin_d   = rmin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    period_d = period_q;
    vmax_d   = vmax_q;
    vmin_d   = vmin_q;
    vpp_d    = vpp_q;

    case (state_q)
      S_IDLE: begin
        if (bus.meas_start) begin
          state_d = S_ARM;
          busy_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      S_ARM: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (!level_q) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (rise_q) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          ncnt_d  = '0;
          rmax_d  = smp;
          rmin_d  = smp;
        end
      end
      S_MEASURE: begin
        tmo_d  = tmo_inc;
        cnt_d  = cnt_inc;
        rmax_d = cur_max;
        rmin_d = cur_min;
        if (tmo_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (rise_q) begin
          if (ncnt_q + 4'd1 == 4'(NCYC)) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            period_d = cnt_inc;
            vmax_d   = cur_max;
            vmin_d   = cur_min;
            vpp_d    = cur_max - cur_min;
          end else begin
            ncnt_d = ncnt_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Disable wins over everything, including a measurement finishing this clock.
    if (!bus.en) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      period_d = period_q;
      vmax_d   = vmax_q;
      vmin_d   = vmin_q;
      vpp_d    = vpp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ncnt_q   <= '0;
      tmo_q    <= '0;
      rmax_q   <= '0;
      rmin_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      period_q <= '0;
      vmax_q   <= '0;
      vmin_q   <= '0;
      vpp_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ncnt_q   <= ncnt_d;
      tmo_q    <= tmo_d;
      rmax_q   <= rmax_d;
      rmin_q   <= rmin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      period_q <= period_d;
      vmax_q   <= vmax_d;
      vmin_q   <= vmin_d;
      vpp_q    <= vpp_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.period = period_q;
  assign bus.vmax   = vmax_q;
  assign bus.vmin   = vmin_q;
  assign bus.vpp    = vpp_q;

endmodule
